// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: fixed-latency word/half/byte load/store on an
// internal word array, with busy and fault flags decoded from registered state only.
module data_mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  readctrl,
    input  logic [1:0]  writectrl,
    input  logic        wrcheck,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        read,
    output logic        write,
    output logic        outofboundaccess,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        wb_en
);

    localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT = 33'(4 * DEPTH);
    localparam logic [1:0]  C_WORD = 2'd0, C_HALF = 2'd1, C_NONE = 2'd3;

    typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY, FAULT} state_t;

    state_t       state, state_nxt;
    logic [3:0]   cnt;
    logic [AW+1:0] cap_addr;
    logic [1:0]   cap_code;
    logic [31:0]  cap_wdata;
    logic         cap_wrcheck;

    logic [31:0]  mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic [31:0]  cur_word, ld_val, st_word;
    logic [7:0]   byte_val;
    logic [15:0]  half_val;

    logic [1:0]   req_code;
    logic         req_store, req_valid, req_fault, done;

    // Store wins over a simultaneous load; the fault check uses the winning code.
    always_comb begin
        req_store = (writectrl != C_NONE);
        req_valid = req_store || (readctrl != C_NONE);
        req_code  = req_store ? writectrl : readctrl;
        req_fault = ({1'b0, addr} >= LIMIT)
                 || ((req_code == C_WORD) && (addr[1:0] != 2'b00))
                 || ((req_code == C_HALF) && addr[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_fault)      state_nxt = FAULT;
                    else if (req_store) state_nxt = WR_BUSY;
                    else                state_nxt = RD_BUSY;
                end
            end
            RD_BUSY, WR_BUSY: if (cnt == 4'd0) state_nxt = IDLE;
            FAULT:            state_nxt = IDLE;
            default:          state_nxt = IDLE;
        endcase
    end

    always_comb begin
        read             = (state == RD_BUSY);
        write            = (state == WR_BUSY);
        outofboundaccess = (state == FAULT);
    end

    assign done     = (state == RD_BUSY || state == WR_BUSY) && (cnt == 4'd0);
    assign word_idx = cap_addr[AW+1:2];
    assign cur_word = mem[word_idx];
    assign byte_val = cur_word[{cap_addr[1:0], 3'b000} +: 8];
    assign half_val = cur_word[{cap_addr[1], 4'b0000} +: 16];

    always_comb begin
        case (cap_code)
            C_WORD:  ld_val = cur_word;
            C_HALF:  ld_val = {{16{half_val[15]}}, half_val};
            default: ld_val = {{24{byte_val[7]}}, byte_val};
        endcase
    end

    // Read-modify-write merge: only the addressed lanes change.
    always_comb begin
        st_word = cur_word;
        case (cap_code)
            C_WORD:  st_word = cap_wdata;
            C_HALF:  st_word[{cap_addr[1], 4'b0000} +: 16] = cap_wdata[15:0];
            default: st_word[{cap_addr[1:0], 3'b000} +: 8] = cap_wdata[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= 4'd0;
            cap_addr    <= '0;
            cap_code    <= C_NONE;
            cap_wdata   <= 32'h0;
            cap_wrcheck <= 1'b0;
            rdata       <= 32'h0;
            rdata_valid <= 1'b0;
            wb_en       <= 1'b0;
        end else begin
            rdata_valid <= 1'b0;
            wb_en       <= 1'b0;
            if (state == IDLE) begin
                if (req_valid && !req_fault) begin
                    cap_addr    <= addr[AW+1:0];
                    cap_code    <= req_code;
                    cap_wdata   <= wdata;
                    cap_wrcheck <= wrcheck;
                    cnt         <= 4'(LATENCY - 1);
                end
            end else if (state == RD_BUSY || state == WR_BUSY) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else if (state == RD_BUSY) begin
                    rdata       <= ld_val;
                    rdata_valid <= 1'b1;
                    wb_en       <= cap_wrcheck;
                end
            end
        end
    end

    // Array is deliberately not reset; a reset forces IDLE, so an in-flight store never lands.
    always_ff @(posedge clk) begin
        if (done && state == WR_BUSY) mem[word_idx] <= st_word;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: table of single accesses plus hand
// sequences for busy-ignore, mid-store reset and a LATENCY=1 back-to-back sweep.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [1:0]  readctrl, writectrl;
    logic        wrcheck;
    logic [31:0] addr, wdata;
    logic        read, write, outofboundaccess, rdata_valid, wb_en;
    logic [31:0] rdata;

    logic [1:0]  l1_readctrl, l1_writectrl;
    logic [31:0] l1_addr, l1_wdata;
    logic        l1_read, l1_write, l1_oob, l1_rdata_valid, l1_wb_en;
    logic [31:0] l1_rdata;

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) dut (
        .clk(clk), .rst_n(rst_n), .readctrl(readctrl), .writectrl(writectrl),
        .wrcheck(wrcheck), .addr(addr), .wdata(wdata), .read(read), .write(write),
        .outofboundaccess(outofboundaccess), .rdata(rdata),
        .rdata_valid(rdata_valid), .wb_en(wb_en));

    data_mem_responder #(.DEPTH(256), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .readctrl(l1_readctrl), .writectrl(l1_writectrl),
        .wrcheck(1'b1), .addr(l1_addr), .wdata(l1_wdata), .read(l1_read),
        .write(l1_write), .outofboundaccess(l1_oob), .rdata(l1_rdata),
        .rdata_valid(l1_rdata_valid), .wb_en(l1_wb_en));

    typedef struct {
        logic [1:0]  rc, wc;
        logic [31:0] a, d;
        logic        wrc;
        int          e_rd, e_wr, e_oob, e_vld;
        logic [31:0] e_data;
        logic        e_wb;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] rc, input logic [1:0] wc,
                                input logic [31:0] a, input logic [31:0] d, input logic wrc,
                                input int rd, input int wr, input int oob, input int vld,
                                input logic [31:0] data, input logic wb);
        vec_t v;
        v.rc = rc; v.wc = wc; v.a = a; v.d = d; v.wrc = wrc;
        v.e_rd = rd; v.e_wr = wr; v.e_oob = oob; v.e_vld = vld;
        v.e_data = data; v.e_wb = wb;
        return v;
    endfunction

    // Issue one request, watch LATENCY+2 cycles, compare flag durations and load result.
    task automatic run_vec(input vec_t v, input string nm);
        int nrd, nwr, noob, nv, vidx;
        logic [31:0] got;
        logic gwb;
        nrd = 0; nwr = 0; noob = 0; nv = 0; vidx = -1; got = 32'h0; gwb = 1'b0;
        @(negedge clk);
        readctrl = v.rc; writectrl = v.wc; addr = v.a; wdata = v.d; wrcheck = v.wrc;
        @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) begin readctrl = 2'd3; writectrl = 2'd3; end
            nrd += int'(read); nwr += int'(write); noob += int'(outofboundaccess);
            if (rdata_valid) begin nv++; vidx = i; got = rdata; gwb = wb_en; end
        end
        chk({nm, " read_cycles"}, nrd, v.e_rd);
        chk({nm, " write_cycles"}, nwr, v.e_wr);
        chk({nm, " oob_cycles"}, noob, v.e_oob);
        chk({nm, " valid_pulses"}, nv, v.e_vld);
        if (v.e_vld != 0) begin
            chk({nm, " valid_slot"}, vidx, 2);
            chk({nm, " rdata"}, got, v.e_data);
            chk({nm, " wb_en"}, {31'b0, gwb}, {31'b0, v.e_wb});
        end
    endtask

    vec_t tbl[23];

    initial begin
        tbl[0]  = mk(3, 0, 32'h10,  32'hDEADBEEF, 0, 0, 2, 0, 0, 32'h0, 0);
        tbl[1]  = mk(0, 3, 32'h10,  32'h0,        1, 2, 0, 0, 1, 32'hDEADBEEF, 1);
        tbl[2]  = mk(3, 0, 32'h10,  32'h0,        0, 0, 2, 0, 0, 32'h0, 0);
        tbl[3]  = mk(3, 2, 32'h11,  32'h12345680, 0, 0, 2, 0, 0, 32'h0, 0);
        tbl[4]  = mk(0, 3, 32'h10,  32'h0,        1, 2, 0, 0, 1, 32'h00008000, 1);
        tbl[5]  = mk(2, 3, 32'h11,  32'h0,        0, 2, 0, 0, 1, 32'hFFFFFF80, 0);
        tbl[6]  = mk(1, 3, 32'h10,  32'h0,        1, 2, 0, 0, 1, 32'hFFFF8000, 1);
        tbl[7]  = mk(0, 3, 32'h12,  32'h0,        1, 0, 0, 1, 0, 32'h0, 0);
        tbl[8]  = mk(3, 0, 32'd1024, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 32'h0, 0);
        tbl[9]  = mk(0, 3, 32'h10,  32'h0,        1, 2, 0, 0, 1, 32'h00008000, 1);
        tbl[10] = mk(3, 0, 32'h14,  32'h11223344, 0, 0, 2, 0, 0, 32'h0, 0);
        tbl[11] = mk(3, 1, 32'h16,  32'hAAAA7FFF, 0, 0, 2, 0, 0, 32'h0, 0);
        tbl[12] = mk(0, 3, 32'h14,  32'h0,        1, 2, 0, 0, 1, 32'h7FFF3344, 1);
        tbl[13] = mk(1, 3, 32'h16,  32'h0,        1, 2, 0, 0, 1, 32'h00007FFF, 1);
        tbl[14] = mk(2, 3, 32'h17,  32'h0,        1, 2, 0, 0, 1, 32'h0000007F, 1);
        tbl[15] = mk(2, 3, 32'h14,  32'h0,        0, 2, 0, 0, 1, 32'h00000044, 0);
        tbl[16] = mk(1, 3, 32'h11,  32'h0,        1, 0, 0, 1, 0, 32'h0, 0);
        tbl[17] = mk(3, 1, 32'h13,  32'hFFFF,     0, 0, 0, 1, 0, 32'h0, 0);
        tbl[18] = mk(3, 2, 32'd1023, 32'h000000C3, 0, 0, 2, 0, 0, 32'h0, 0);
        tbl[19] = mk(2, 3, 32'd1023, 32'h0,       1, 2, 0, 0, 1, 32'hFFFFFFC3, 1);
        tbl[20] = mk(0, 0, 32'h20,  32'h5555AAAA, 1, 0, 2, 0, 0, 32'h0, 0);
        tbl[21] = mk(0, 3, 32'h20,  32'h0,        1, 2, 0, 0, 1, 32'h5555AAAA, 1);
        tbl[22] = mk(3, 0, 32'h28,  32'h0BADF00D, 0, 0, 2, 0, 0, 32'h0, 0);

        rst_n = 1'b0;
        readctrl = 2'd3; writectrl = 2'd3; wrcheck = 1'b0; addr = 32'h0; wdata = 32'h0;
        l1_readctrl = 2'd3; l1_writectrl = 2'd3; l1_addr = 32'h0; l1_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset flags", {28'b0, read, write, outofboundaccess, rdata_valid}, 32'h0);
        chk("reset wb_en", {31'b0, wb_en}, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 23; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Requests offered while a store is busy must be dropped.
        @(negedge clk);
        writectrl = 2'd0; addr = 32'h24; wdata = 32'h1;
        @(posedge clk);
        @(negedge clk);
        chk("busy write_high", {31'b0, write}, 32'h1);
        writectrl = 2'd0; readctrl = 2'd0; addr = 32'h28; wdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("busy read_low", {31'b0, read}, 32'h0);
        writectrl = 2'd3; readctrl = 2'd3;
        repeat (2) @(negedge clk);
        chk("busy idle_after", {30'b0, read, write}, 32'h0);
        run_vec(mk(0, 3, 32'h28, 32'h0, 1, 2, 0, 0, 1, 32'h0BADF00D, 1), "ignored_addr");
        run_vec(mk(0, 3, 32'h24, 32'h0, 0, 2, 0, 0, 1, 32'h00000001, 0), "busy_store");

        // Reset in the middle of a store aborts it.
        @(negedge clk);
        writectrl = 2'd0; addr = 32'h10; wdata = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        writectrl = 2'd3;
        chk("midrst write_before", {31'b0, write}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst flags", {27'b0, read, write, outofboundaccess, rdata_valid, wb_en}, 32'h0);
        chk("midrst rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mk(0, 3, 32'h10, 32'h0, 1, 2, 0, 0, 1, 32'h00008000, 1), "midrst_old");

        // LATENCY=1 instance: preload eight words, then stream eight loads.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            l1_writectrl = 2'd0; l1_addr = 32'(4 * k); l1_wdata = 32'h10000000 + 32'(k * 32'h0101);
            @(posedge clk);
            @(negedge clk);
            l1_writectrl = 2'd3;
            @(negedge clk);
        end
        @(negedge clk);
        l1_readctrl = 2'd0; l1_addr = 32'h0;
        for (int n = 1; n <= 17; n++) begin
            logic exp_rd, exp_v;
            @(negedge clk);
            exp_rd = (n % 2 == 1) && (n <= 15);
            exp_v  = (n % 2 == 0) && (n >= 2) && (n <= 16);
            chk($sformatf("l1 n%0d read/valid", n), {30'b0, l1_read, l1_rdata_valid},
                {30'b0, exp_rd, exp_v});
            if (exp_v)
                chk($sformatf("l1 n%0d rdata", n), l1_rdata,
                    32'h10000000 + 32'((n / 2 - 1) * 32'h0101));
            if (n % 2 == 1) begin
                if (n == 15) l1_readctrl = 2'd3;
                else         l1_addr = 32'(4 * ((n + 1) / 2));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder at the far end of the MEM-stage read/write control path. Accepts 2-bit load/store control codes, address, store data and writeback flag from the control mux. Performs a fixed-latency word/halfword/byte access on an internal word array. Drives back the `read`/`write` busy flags and `outofboundaccess` fault flag that the mux uses to squash further requests.

## Interface
- `DEPTH`, 256: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH-1.
- `LATENCY`, 2: busy cycles per access; legal range 1..15.

- `clk` in 1: clock; all state updates on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `readctrl` in 2: load code; 0 = word, 1 = halfword, 2 = byte, 3 = none.
- `writectrl` in 2: store code; same encoding as `readctrl`.
- `wrcheck` in 1: register-writeback enable that accompanies a load.
- `addr` in 32: byte address.
- `wdata` in 32: store data; half/byte use the low 16/8 bits.
- `read` out 1: high while a load is in progress.
- `write` out 1: high while a store is in progress.
- `outofboundaccess` out 1: one-cycle fault pulse.
- `rdata` out 32: load result, sign-extended for half/byte.
- `rdata_valid` out 1: one-cycle pulse qualifying `rdata`.
- `wb_en` out 1: equals the captured `wrcheck` while `rdata_valid` is high; 0 otherwise.

## Operation
- States: IDLE, RD_BUSY, WR_BUSY, FAULT. A down-counter `cnt` has width 4.
- Requests are sampled only in IDLE. In any other state, inputs are ignored and nothing is queued.
- IDLE decode at the clock edge:
  - `writectrl` != 3 means a store request. It takes priority; a simultaneous `readctrl` != 3 is dropped.
  - Otherwise `readctrl` != 3 means a load request.
  - Both codes equal to 3: stay in IDLE.
- Fault check on the accepted request, using its code:
  - The request faults if `addr` >= 4*DEPTH.
  - A word access faults if `addr[1:0]` != 0.
  - A halfword access faults if `addr[0]` != 0.
  - A faulting request goes to FAULT. No memory access occurs, and `wbdata`/`wb_en` are not produced.
- On acceptance: capture addr, code, wdata and wrcheck; load `cnt` = LATENCY-1; enter RD_BUSY or WR_BUSY.
- Busy states: each edge with `cnt` != 0 decrements `cnt`. The edge with `cnt` == 0 completes the access and returns to IDLE.
- Store completion:
  - The array word at `addr[..:2]` is updated at the completing edge. Layout is little-endian.
  - Byte store writes lane `addr[1:0]`. Halfword store writes lanes {addr[1],1'b1}:{addr[1],1'b0}. Other lanes are unchanged.
- Load completion:
  - `rdata` is registered from the selected lanes at the completing edge.
  - Byte/half results are sign-extended to 32 bits; word is passed through.
  - `rdata_valid` is set to 1 and `wb_en` to the captured wrcheck for exactly one cycle.
- FAULT lasts one cycle, with `outofboundaccess` = 1, then returns to IDLE.
- `read` = (state == RD_BUSY), `write` = (state == WR_BUSY), `outofboundaccess` = (state == FAULT). All three are decoded from registered state only, so there is no combinational path from any input; this prevents a loop through the control mux.
- Memory array is not reset. Contents persist across `rst_n`.

## Timing
- Reset (async assert):
  - State goes to IDLE and `cnt` to 0.
  - `read`, `write`, `outofboundaccess`, `rdata_valid` and `wb_en` go to 0, and `rdata` to 32'h0.
  - An in-flight store is aborted with no array write. An in-flight load produces no `rdata_valid`.
- Deassertion is released at the next edge. The first request is sampled on the first edge with `rst_n` high.
- Load with request at edge E0:
  - `read` is high for cycles E0..E0+LATENCY-1, i.e. LATENCY cycles.
  - `rdata_valid`/`wb_en` are high in the cycle after E0+LATENCY, coincident with the first IDLE cycle.
- Store with request at edge E0: `write` is high for LATENCY cycles. The array is updated at edge E0+LATENCY.
- A new request can be sampled in the first IDLE cycle after completion, i.e. the same cycle that `rdata_valid` is high. Back-to-back throughput is one access per LATENCY+1 cycles.
- Fault with request at edge E0: `outofboundaccess` is high for exactly one cycle after E0, then IDLE.
- A load issued immediately after a store to the same address returns the stored value, since the store has already completed.

## Test plan
- Store word 32'hDEADBEEF to addr 0x10 (writectrl=0), then load word from 0x10 (readctrl=0, wrcheck=1) with LATENCY=2:
  - `write` is high 2 cycles.
  - `read` is high 2 cycles, then `rdata`=32'hDEADBEEF with `rdata_valid`=1 and `wb_en`=1 for 1 cycle.
- Store byte 8'h80 to 0x11 over existing word 32'h00000000:
  - Load word returns 32'h00008000.
  - Load byte from 0x11 returns 32'hFFFFFF80.
  - Load halfword from 0x10 returns 32'hFFFF8000.
- Load word from 0x12 (misaligned), and store to addr 4*DEPTH (1024):
  - Each gives `outofboundaccess` high exactly 1 cycle, with `read`/`write` never high.
  - Array is unchanged and `rdata_valid` stays 0.
- Simultaneous readctrl=0 and writectrl=0 in IDLE:
  - The store is performed and `read` stays 0.
  - Requests presented while `write`=1 are ignored, leaving the array unchanged at those addresses.
- Assert `rst_n`=0 mid-store (`write` high, `cnt`>0):
  - All outputs go to 0 immediately.
  - A subsequent load of that address returns the old value.
- LATENCY=1 sweep of 8 back-to-back loads: each has `read` high for 1 cycle, with `rdata_valid` pulses 2 cycles apart.
